rca_dispatch_unit: RTL and testbench

Parametrised dispatch front-end for the reconfigurable custom accelerator (RCA) array. Accepts decoded RCA-opcode instructions from the issue stage, sorts them into configuration writes (CPU_REG/GRID_MUX/IO_MUX/RESULT_MUX/IO_USE) and use operations (USE_FB/USE_NFB), and targets one of `NUM_RCAS` accelerators selected by fn7. Configuration writes are buffered in a FIFO and drained onto a config bus. Use operations are held back while that accelerator still has configuration pending, so execution order matches program order.

---
 rtl/rca_dispatch_unit_pkg.sv | 32 +++
 rtl/riscv_types_pkg.sv | 16 +
 rtl/rca_dispatch_unit_cfg_fifo.sv | 54 +++++
 rtl/rca_dispatch_unit.sv | 170 +++++++++++++++++
 tb/tb_rca_dispatch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rca_dispatch_unit_pkg.sv
// Request structs and decode helpers shared by the RCA dispatch front-end and its config FIFO.
package rca_dispatch_unit_pkg;
    import riscv_types_pkg::*;

    localparam int RCA_MAX_UNITS = 32;
    localparam int RCA_SEL_MAX_W = $clog2(RCA_MAX_UNITS);

    typedef struct packed {
        logic [RCA_SEL_MAX_W-1:0] sel;
        logic [2:0]               cfg_type;
        logic [31:0]              data1;
        logic [31:0]              data2;
    } rca_cfg_req_t;

    typedef struct packed {
        logic [RCA_SEL_MAX_W-1:0] sel;
        logic                     fb;
        logic [31:0]              rs1;
        logic [31:0]              rs2;
        logic [4:0]               rd_addr;
    } rca_use_req_t;

    function automatic logic rca_is_cfg_op(input logic [2:0] fn3);
        return (fn3 == RCA_CPU_REG) || (fn3 == RCA_GRID_MUX) || (fn3 == RCA_IO_MUX) ||
               (fn3 == RCA_RESULT_MUX) || (fn3 == RCA_IO_USE);
    endfunction

    function automatic logic rca_is_use_op(input logic [2:0] fn3);
        return (fn3 == RCA_USE_FB) || (fn3 == RCA_USE_NFB);
    endfunction

endpackage

// File: rtl/riscv_types_pkg.sv
// Shared RISC-V decode types; only the RCA custom-opcode function encodings live here for now.
package riscv_types_pkg;

    typedef enum logic [2:0] {
        RCA_USE_FB     = 3'b000,
        RCA_CPU_REG    = 3'b001,
        RCA_GRID_MUX   = 3'b010,
        RCA_IO_MUX     = 3'b011,
        RCA_RESULT_MUX = 3'b100,
        RCA_IO_USE     = 3'b101,
        RCA_USE_NFB    = 3'b110
    } rca_fn3_e;

    localparam logic [6:0] RCA_FN7_ENABLE = 7'b100_0000;

endpackage

// File: rtl/rca_dispatch_unit_cfg_fifo.sv
// rca_cfg_fifo: parametrised FIFO with registered head and occupancy count.
module rca_cfg_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Push is refused when full even if a pop happens the same cycle, so there is no pass-through.
    assign do_push  = push && (count != CNT_W'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign pop_data = mem[rd_ptr];
    assign valid    = (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rca_dispatch_unit.sv
// RCA dispatch front-end: config writes queue into a FIFO, use ops wait until their target's config drains.
// Optional build macro RCA_ILLEGAL_TRAP_EN makes consumed illegal encodings pulse illegal_valid.
module rca_dispatch_unit
    import riscv_types_pkg::*, rca_dispatch_unit_pkg::*;
#(
    parameter int NUM_RCAS       = 4,
    parameter int CFG_FIFO_DEPTH = 4,
    localparam int SEL_W = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
    localparam int CNT_W = $clog2(CFG_FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [6:0]          issue_fn7,
    input  logic [2:0]          issue_fn3,
    input  logic [31:0]         issue_rs1,
    input  logic [31:0]         issue_rs2,
    input  logic [4:0]          issue_rd_addr,
    output logic                cfg_valid,
    input  logic                cfg_ready,
    output logic [SEL_W-1:0]    cfg_sel,
    output logic [2:0]          cfg_type,
    output logic [31:0]         cfg_data1,
    output logic [31:0]         cfg_data2,
    output logic                use_valid,
    input  logic                use_ready,
    output logic [SEL_W-1:0]    use_sel,
    output logic                use_fb,
    output logic [31:0]         use_rs1,
    output logic [31:0]         use_rs2,
    output logic [4:0]          use_rd_addr,
    output logic [NUM_RCAS-1:0] cfg_pending,
    output logic                illegal_valid
);

    typedef enum logic {USE_EMPTY, USE_FULL} use_state_e;

    use_state_e    use_state;
    use_state_e    use_state_next;
    rca_use_req_t  use_q;
    rca_cfg_req_t  fifo_head;
    rca_cfg_req_t  fifo_in;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] pend_cnt [NUM_RCAS];
    logic [NUM_RCAS-1:0] pend_inc;
    logic [NUM_RCAS-1:0] pend_dec;
    logic [SEL_W-1:0] sel;
    logic is_legal;
    logic is_cfg;
    logic is_use;
    logic cfg_accept;
    logic use_accept;
    logic cfg_hs;

    // An index below NUM_RCAS also guarantees fn7[5:SEL_W] is zero, since NUM_RCAS <= 2**SEL_W.
    assign sel      = issue_fn7[SEL_W-1:0];
    assign is_legal = issue_fn7[6] && (issue_fn7[5:0] < 6'(NUM_RCAS)) && (issue_fn3 != 3'b111);
    assign is_cfg   = is_legal && rca_is_cfg_op(issue_fn3);
    assign is_use   = is_legal && rca_is_use_op(issue_fn3);

    always_comb begin
        issue_ready = 1'b1;
        if (is_cfg) begin
            issue_ready = (fifo_count < CNT_W'(CFG_FIFO_DEPTH));
        end else if (is_use) begin
            issue_ready = ((use_state == USE_EMPTY) || use_ready) && !cfg_pending[sel];
        end
    end

    assign cfg_accept = issue_valid && issue_ready && is_cfg;
    assign use_accept = issue_valid && issue_ready && is_use;
    assign cfg_hs     = cfg_valid && cfg_ready;

    assign fifo_in = '{sel: RCA_SEL_MAX_W'(sel), cfg_type: issue_fn3,
                       data1: issue_rs1, data2: issue_rs2};

    rca_cfg_fifo #(
        .DEPTH (CFG_FIFO_DEPTH),
        .WIDTH ($bits(rca_cfg_req_t))
    ) u_cfg_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cfg_accept),
        .push_data (fifo_in),
        .pop       (cfg_hs),
        .pop_data  (fifo_head),
        .valid     (cfg_valid),
        .count     (fifo_count)
    );

    assign cfg_sel   = SEL_W'(fifo_head.sel);
    assign cfg_type  = fifo_head.cfg_type;
    assign cfg_data1 = fifo_head.data1;
    assign cfg_data2 = fifo_head.data2;

    always_comb begin
        pend_inc    = '0;
        pend_dec    = '0;
        cfg_pending = '0;
        for (int i = 0; i < NUM_RCAS; i++) begin
            pend_inc[i]    = cfg_accept && (sel == SEL_W'(i));
            pend_dec[i]    = cfg_hs && (cfg_sel == SEL_W'(i));
            cfg_pending[i] = (pend_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RCAS; i++) begin
                pend_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RCAS; i++) begin
                if (pend_inc[i] && !pend_dec[i]) begin
                    pend_cnt[i] <= pend_cnt[i] + CNT_W'(1);
                end else if (pend_dec[i] && !pend_inc[i]) begin
                    pend_cnt[i] <= pend_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            use_state <= USE_EMPTY;
            use_q     <= '0;
        end else begin
            use_state <= use_state_next;
            if (use_accept) begin
                use_q <= '{sel: RCA_SEL_MAX_W'(sel), fb: (issue_fn3 == RCA_USE_FB),
                           rs1: issue_rs1, rs2: issue_rs2, rd_addr: issue_rd_addr};
            end
        end
    end

    // A new accept while draining keeps the slot full with the fresh op.
    always_comb begin
        use_state_next = use_state;
        case (use_state)
            USE_EMPTY: if (use_accept) use_state_next = USE_FULL;
            USE_FULL:  if (use_ready && !use_accept) use_state_next = USE_EMPTY;
            default:   use_state_next = USE_EMPTY;
        endcase
    end

    assign use_valid   = (use_state == USE_FULL);
    assign use_sel     = SEL_W'(use_q.sel);
    assign use_fb      = use_q.fb;
    assign use_rs1     = use_q.rs1;
    assign use_rs2     = use_q.rs2;
    assign use_rd_addr = use_q.rd_addr;

`ifdef RCA_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= issue_valid && !is_legal;
        end
    end

    assign illegal_valid = illegal_q;
`else
    assign illegal_valid = 1'b0;
`endif

endmodule

// File: tb/tb_rca_dispatch_unit.sv
// Self-checking bench for rca_dispatch_unit: queue-based reference model plus directed scenarios.
module tb_rca_dispatch_unit;

    localparam int NUM   = 4;
    localparam int DEPTH = 4;
    localparam int SEL_W = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic issue_valid, issue_ready;
    logic [6:0] issue_fn7;
    logic [2:0] issue_fn3;
    logic [31:0] issue_rs1, issue_rs2;
    logic [4:0] issue_rd_addr;
    logic cfg_valid, cfg_ready;
    logic [SEL_W-1:0] cfg_sel;
    logic [2:0] cfg_type;
    logic [31:0] cfg_data1, cfg_data2;
    logic use_valid, use_ready;
    logic [SEL_W-1:0] use_sel;
    logic use_fb;
    logic [31:0] use_rs1, use_rs2;
    logic [4:0] use_rd_addr;
    logic [NUM-1:0] cfg_pending;
    logic illegal_valid;

    always #5 clk = ~clk;

    rca_dispatch_unit #(.NUM_RCAS(NUM), .CFG_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_fn7(issue_fn7), .issue_fn3(issue_fn3),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd_addr(issue_rd_addr),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_type(cfg_type),
        .cfg_data1(cfg_data1), .cfg_data2(cfg_data2),
        .use_valid(use_valid), .use_ready(use_ready), .use_sel(use_sel), .use_fb(use_fb),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .use_rd_addr(use_rd_addr),
        .cfg_pending(cfg_pending), .illegal_valid(illegal_valid)
    );

    int checks = 0;
    int failures = 0;
    int illegal_pulses = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: an ordered list of outstanding config writes and a single held use op.
    typedef struct {
        int          sel;
        logic [2:0]  typ;
        logic [31:0] d1;
        logic [31:0] d2;
    } cfg_entry_t;

    cfg_entry_t  m_cfg[$];
    bit          m_use_full = 0;
    int          m_use_sel;
    bit          m_use_fb;
    logic [31:0] m_use_rs1, m_use_rs2;
    logic [4:0]  m_use_rd;
    bit          m_illegal = 0;

    // 0 = illegal, 1 = config write, 2 = use op
    function automatic int classify(input logic [6:0] fn7, input logic [2:0] fn3);
        int f;
        f = fn7;
        if (f < 64 || (f % 64) >= NUM || fn3 == 3'd7) return 0;
        if (fn3 == 3'd0 || fn3 == 3'd6) return 2;
        return 1;
    endfunction

    function automatic int pendingOf(input int s);
        int n = 0;
        foreach (m_cfg[k]) if (m_cfg[k].sel == s) n++;
        return n;
    endfunction

    function automatic logic [NUM-1:0] modelPending();
        logic [NUM-1:0] v = '0;
        for (int s = 0; s < NUM; s++) v[s] = (pendingOf(s) > 0);
        return v;
    endfunction

    function automatic logic modelReady();
        int c, f;
        c = classify(issue_fn7, issue_fn3);
        f = issue_fn7;
        if (c == 1) return (m_cfg.size() < DEPTH);
        if (c == 2) return (!m_use_full || use_ready) && (pendingOf(f % 64) == 0);
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_cfg.delete();
            m_use_full = 0;
            m_illegal  = 0;
        end else begin
            logic exp_ready;
            int cls, f;
            cfg_entry_t e;
            exp_ready = modelReady();
            checkOutput("issue_ready", issue_ready, exp_ready);
            checkOutput("cfg_valid", cfg_valid, (m_cfg.size() != 0));
            if (m_cfg.size() != 0) begin
                checkOutput("cfg_sel", cfg_sel, m_cfg[0].sel);
                checkOutput("cfg_type", cfg_type, m_cfg[0].typ);
                checkOutput("cfg_data1", cfg_data1, m_cfg[0].d1);
                checkOutput("cfg_data2", cfg_data2, m_cfg[0].d2);
            end
            checkOutput("cfg_pending", cfg_pending, modelPending());
            checkOutput("use_valid", use_valid, m_use_full);
            if (m_use_full) begin
                checkOutput("use_sel", use_sel, m_use_sel);
                checkOutput("use_fb", use_fb, m_use_fb);
                checkOutput("use_rs1", use_rs1, m_use_rs1);
                checkOutput("use_rs2", use_rs2, m_use_rs2);
                checkOutput("use_rd_addr", use_rd_addr, m_use_rd);
            end
            checkOutput("illegal_valid", illegal_valid, m_illegal);
            if (illegal_valid) illegal_pulses++;

            // advance the model by the upcoming rising edge
            if (m_cfg.size() != 0 && cfg_ready) void'(m_cfg.pop_front());
            if (m_use_full && use_ready) m_use_full = 0;
            m_illegal = 0;
            if (issue_valid && exp_ready) begin
                cls = classify(issue_fn7, issue_fn3);
                f = issue_fn7;
                if (cls == 1) begin
                    e.sel = f % 64; e.typ = issue_fn3; e.d1 = issue_rs1; e.d2 = issue_rs2;
                    m_cfg.push_back(e);
                end else if (cls == 2) begin
                    m_use_full = 1;
                    m_use_sel  = f % 64;
                    m_use_fb   = (issue_fn3 == 3'd0);
                    m_use_rs1  = issue_rs1;
                    m_use_rs2  = issue_rs2;
                    m_use_rd   = issue_rd_addr;
                end else begin
`ifdef RCA_ILLEGAL_TRAP_EN
                    m_illegal = 1;
`endif
                end
            end
        end
    end

    task automatic waitAccept(input int budget);
        int n = 0;
        @(negedge clk);
        while (!issue_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("issue_accept", issue_ready, 1'b1);
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [6:0] fn7, input logic [2:0] fn3,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [4:0] rd, input int budget);
        issue_valid   = 1'b1;
        issue_fn7     = fn7;
        issue_fn3     = fn3;
        issue_rs1     = rs1;
        issue_rs2     = rs2;
        issue_rd_addr = rd;
        waitAccept(budget);
    endtask

    task automatic drainCfg(input int budget);
        int n = 0;
        cfg_ready = 1'b1;
        while (cfg_valid && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("cfg_drain", cfg_valid, 1'b0);
        cfg_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the scenario list completed");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;
        int exp_pulses;
        issue_valid = 0; issue_fn7 = '0; issue_fn3 = '0;
        issue_rs1 = '0; issue_rs2 = '0; issue_rd_addr = '0;
        cfg_ready = 0; use_ready = 0;

        #2;
        checkOutput("rst_cfg_valid", cfg_valid, 1'b0);
        checkOutput("rst_use_valid", use_valid, 1'b0);
        checkOutput("rst_cfg_pending", cfg_pending, '0);
        checkOutput("rst_illegal", illegal_valid, 1'b0);
        checkOutput("rst_cfg_data1", cfg_data1, '0);
        checkOutput("rst_use_rs1", use_rs1, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] GRID_MUX config to RCA 2");
        applyStimulus(7'h42, 3'b010, 32'h1234_5678, 32'hCAFE_F00D, 5'd0, 4);
        checkOutput("t1_cfg_valid", cfg_valid, 1'b1);
        checkOutput("t1_cfg_sel", cfg_sel, 2);
        checkOutput("t1_cfg_type", cfg_type, 3'b010);
        checkOutput("t1_cfg_data1", cfg_data1, 32'h1234_5678);
        checkOutput("t1_cfg_pending", cfg_pending, 4'b0100);
        drainCfg(20);

        $display("[TB] FIFO full back-pressure");
        for (int i = 0; i < 4; i++) applyStimulus(7'h41, 3'b011, 32'h100 + i, 32'h200 + i, 5'd0, 2);
        issue_valid = 1; issue_fn7 = 7'h41; issue_fn3 = 3'b011; issue_rs1 = 32'h104; issue_rs2 = 32'h204;
        @(negedge clk);
        checkOutput("t2_full_stall", issue_ready, 1'b0);
        @(posedge clk); #1;
        cfg_ready = 1;
        @(posedge clk); #1;
        cfg_ready = 0;
        @(negedge clk);
        checkOutput("t2_ready_back", issue_ready, 1'b1);
        @(posedge clk); #1;
        issue_valid = 0;
        checkOutput("t2_pending", cfg_pending, 4'b0010);
        drainCfg(20);

        $display("[TB] use ordering behind pending config");
        use_ready = 1;
        applyStimulus(7'h43, 3'b001, 32'hA5A5_0003, 32'h3, 5'd0, 2);
        applyStimulus(7'h40, 3'b110, 32'h0000_0BEE, 32'h1, 5'd7, 0);
        checkOutput("t3_nfb_valid", use_valid, 1'b1);
        checkOutput("t3_nfb_fb", use_fb, 1'b0);
        checkOutput("t3_nfb_sel", use_sel, 0);
        issue_valid = 1; issue_fn7 = 7'h43; issue_fn3 = 3'b000;
        issue_rs1 = 32'hFEED_0003; issue_rs2 = 32'h33; issue_rd_addr = 5'd9;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t3_fb_blocked", issue_ready, 1'b0);
        end
        @(posedge clk); #1;
        cfg_ready = 1;
        waitAccept(4);
        cfg_ready = 0;
        checkOutput("t3_fb_valid", use_valid, 1'b1);
        checkOutput("t3_fb_fb", use_fb, 1'b1);
        checkOutput("t3_fb_sel", use_sel, 3);
        checkOutput("t3_fb_rs1", use_rs1, 32'hFEED_0003);
        @(posedge clk); #1;

        $display("[TB] use slot stall and back-to-back");
        use_ready = 0;
        applyStimulus(7'h41, 3'b000, 32'h1111_1111, 32'h2222_2222, 5'd3, 2);
        issue_valid = 1; issue_fn7 = 7'h42; issue_fn3 = 3'b110;
        issue_rs1 = 32'h3333_3333; issue_rs2 = 32'h4444_4444; issue_rd_addr = 5'd4;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t4_stall", issue_ready, 1'b0);
            checkOutput("t4_hold_rs1", use_rs1, 32'h1111_1111);
        end
        @(posedge clk); #1;
        use_ready = 1;
        waitAccept(2);
        checkOutput("t4_b_rs1", use_rs1, 32'h3333_3333);
        applyStimulus(7'h40, 3'b000, 32'h5555_5555, 32'h6666_6666, 5'd5, 0);
        checkOutput("t4_c_rs1", use_rs1, 32'h5555_5555);
        @(posedge clk); #1;
        use_ready = 0;

        $display("[TB] illegal encodings");
        p0 = illegal_pulses;
        applyStimulus(7'h0B, 3'b010, 32'h1, 32'h2, 5'd1, 0);
        applyStimulus(7'h41, 3'b111, 32'h3, 32'h4, 5'd2, 0);
        repeat (3) @(posedge clk);
        #1;
`ifdef RCA_ILLEGAL_TRAP_EN
        exp_pulses = 2;
`else
        exp_pulses = 0;
`endif
        checkOutput("t5_illegal_pulses", illegal_pulses - p0, exp_pulses);
        checkOutput("t5_no_cfg", cfg_valid, 1'b0);

        $display("[TB] asynchronous reset with queued work");
        applyStimulus(7'h40, 3'b001, 32'hAAAA_0000, 32'h0, 5'd0, 2);
        applyStimulus(7'h41, 3'b100, 32'hAAAA_0001, 32'h1, 5'd0, 2);
        applyStimulus(7'h42, 3'b101, 32'hAAAA_0002, 32'h2, 5'd0, 2);
        applyStimulus(7'h43, 3'b110, 32'hBBBB_0003, 32'h3, 5'd6, 2);
        #2;
        rst_n = 0;
        #1;
        checkOutput("t6_cfg_valid", cfg_valid, 1'b0);
        checkOutput("t6_use_valid", use_valid, 1'b0);
        checkOutput("t6_cfg_pending", cfg_pending, '0);
        checkOutput("t6_cfg_data1", cfg_data1, '0);
        checkOutput("t6_cfg_sel", cfg_sel, '0);
        checkOutput("t6_use_rs1", use_rs1, '0);
        checkOutput("t6_use_rd", use_rd_addr, '0);
        checkOutput("t6_illegal", illegal_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1;
        cfg_ready = 1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t6_cfg_idle", cfg_valid, 1'b0);
        end
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
